// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back,
// handshakes with the shared memory port and an optional mul/div unit, counts retirements.
module multicycle_control #(
    parameter int MULDIV_EN = 0,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             alu_zero,
    input  logic             alu_last_bit,
    input  logic             mem_ready,
    input  logic             muldiv_done,
    output logic             mem_req,
    output logic             mem_we,
    output logic             adr_source,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_control,
    output logic [2:0]       imm_source,
    output logic [1:0]       result_src,
    output logic             muldiv_start,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [1:0] A_PC     = 2'b00;
    localparam logic [1:0] A_OLDPC  = 2'b01;
    localparam logic [1:0] A_RS1    = 2'b10;
    localparam logic [1:0] A_ZERO   = 2'b11;
    localparam logic [1:0] B_RS2    = 2'b00;
    localparam logic [1:0] B_IMM    = 2'b01;
    localparam logic [1:0] B_FOUR   = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_MULDIV = 2'b11;

    typedef enum logic [4:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_MULDIV,
        S_BRANCH,
        S_JALRADR,
        S_JAL,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    state_t state;
    state_t state_next;
    logic   md_busy;
    logic   md_ack;
    logic   muldiv_sel;
    logic   func7_std;
    logic   branch_taken;
    logic   branch_bad;
    logic [3:0] branch_alu;

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    assign muldiv_sel = (MULDIV_EN != 0) && (func7 == 7'b0000001);
    assign func7_std  = (func7 == 7'b0000000) || (func7 == 7'b0100000);
    // md_busy masks the entry cycle so a done pulse coincident with start is ignored.
    assign md_ack     = md_busy && muldiv_done;

    always_comb begin
        branch_taken = 1'b0;
        branch_alu   = ALU_ADD;
        branch_bad   = 1'b0;
        case (func3)
            3'b000: begin branch_taken = alu_zero;      branch_alu = ALU_SUB;  end
            3'b001: begin branch_taken = !alu_zero;     branch_alu = ALU_SUB;  end
            3'b100: begin branch_taken = alu_last_bit;  branch_alu = ALU_SLT;  end
            3'b101: begin branch_taken = !alu_last_bit; branch_alu = ALU_SLT;  end
            3'b110: begin branch_taken = alu_last_bit;  branch_alu = ALU_SLTU; end
            3'b111: begin branch_taken = !alu_last_bit; branch_alu = ALU_SLTU; end
            default: branch_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RESET;
            md_busy <= 1'b0;
        end else begin
            state   <= state_next;
            md_busy <= (state == S_MULDIV);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RESET:  state_next = S_FETCH;
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_I:              state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALRADR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECR: begin
                if (muldiv_sel)      state_next = S_MULDIV;
                else if (func7_std)  state_next = S_ALUWB;
                else                 state_next = S_TRAP;
            end
            S_EXECI:   state_next = S_ALUWB;
            S_ALUWB:   state_next = S_FETCH;
            S_MULDIV:  if (md_ack) state_next = S_FETCH;
            S_BRANCH:  state_next = branch_bad ? S_TRAP : S_FETCH;
            S_JALRADR: state_next = S_JAL;
            S_JAL:     state_next = S_ALUWB;
            S_LUI:     state_next = S_ALUWB;
            S_AUIPC:   state_next = S_ALUWB;
            S_TRAP:    state_next = S_TRAP;
            default:   state_next = S_TRAP;
        endcase
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        adr_source    = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = A_PC;
        alu_src_b     = B_RS2;
        alu_control   = ALU_ADD;
        imm_source    = IMM_I;
        result_src    = RES_ALUOUT;
        muldiv_start  = 1'b0;
        illegal_instr = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = A_PC;
                alu_src_b  = B_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            // ALUOut captures the branch/JAL target while the opcode is dispatched.
            S_DECODE: begin
                alu_src_a = A_OLDPC;
                alu_src_b = B_IMM;
                case (op)
                    OP_STORE:         imm_source = IMM_S;
                    OP_BRANCH:        imm_source = IMM_B;
                    OP_JAL:           imm_source = IMM_J;
                    OP_LUI, OP_AUIPC: imm_source = IMM_U;
                    default:          imm_source = IMM_I;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = A_RS1;
                alu_src_b  = B_IMM;
                imm_source = (op == OP_LOAD) ? IMM_I : IMM_S;
            end
            S_MEMREAD: begin
                mem_req    = 1'b1;
                adr_source = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                adr_source = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = A_RS1;
                alu_src_b   = B_RS2;
                alu_control = alu_decode(func3, func7[5]);
            end
            S_EXECI: begin
                alu_src_a   = A_RS1;
                alu_src_b   = B_IMM;
                alu_control = alu_decode(func3, (func3 == 3'b101) && func7[5]);
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
            end
            S_MULDIV: begin
                muldiv_start = !md_busy;
                if (md_ack) begin
                    result_src = RES_MULDIV;
                    reg_write  = 1'b1;
                end
            end
            S_BRANCH: begin
                alu_src_a   = A_RS1;
                alu_src_b   = B_RS2;
                alu_control = branch_alu;
                result_src  = RES_ALUOUT;
                pc_write    = branch_taken;
            end
            S_JALRADR: begin
                alu_src_a = A_RS1;
                alu_src_b = B_IMM;
            end
            // PC takes the target from ALUOut while the ALU forms the link address.
            S_JAL: begin
                pc_write   = 1'b1;
                result_src = RES_ALUOUT;
                alu_src_a  = A_OLDPC;
                alu_src_b  = B_FOUR;
            end
            S_LUI: begin
                alu_src_a  = A_ZERO;
                alu_src_b  = B_IMM;
                imm_source = IMM_U;
            end
            S_AUIPC: begin
                alu_src_a  = A_OLDPC;
                alu_src_b  = B_IMM;
                imm_source = IMM_U;
            end
            S_TRAP:  illegal_instr = 1'b1;
            default: ;
        endcase
    end

    // Every return to FETCH retires one instruction; leaving reset does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (state != S_RESET && state != S_FETCH && state_next == S_FETCH) begin
            instret <= instret + CNT_W'(1);
        end
    end

endmodule
